// File: rtl/mux41_scan_ctrl.sv
// ============================================================================
// mux41_scan_ctrl
// ----------------------------------------------------------------------------
// Scan sequencer for a downstream 4x1 mux. It steps the mux select through the
// enabled channels in ascending order. Each channel stays selected for DWELL
// cycles, and the mux output is sampled on the last edge of that dwell. Once
// every enabled channel has been visited, the sampled bits are published as one
// 4-bit capture word.
//
// Parameters
//   DWELL      cycles each channel stays selected before it is sampled (1..255)
//   CW         dwell counter width, 2**CW > DWELL
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      scan request, honoured only while idle
//   continuous 1 = start a new scan straight after each done
//   ch_mask    channel enable mask, snapshotted at scan start
//   mux_out    OUT of the downstream 4x1 mux
//   sel        registered select to the 4x1 mux
//   busy       registered, scan in progress
//   done       registered one-cycle pulse when captured updates
//   captured   registered capture word, masked channels read as 0
// ============================================================================
module mux41_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] ch_mask,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] captured
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL_S = 2'd1,
        DONE_S  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t         state_q,    state_d;
    logic [1:0]     sel_q,      sel_d;
    logic           busy_q,     busy_d;
    logic           done_q,     done_d;
    logic [3:0]     captured_q, captured_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic [3:0]     shadow_q,   shadow_d;
    logic [3:0]     mask_q,     mask_d;

    logic [2:0]     first_s;
    logic [2:0]     next_s;

    // Lowest enabled channel at or above 'lo'. Bit 2 = found, bits 1:0 = index.
    // The scan runs from high to low so that the lowest match is kept last.
    function automatic logic [2:0] find_ch(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            r = (m[i] && (3'(i) >= lo)) ? {1'b1, 2'(i)} : r;
        end
        return r;
    endfunction

    // First channel of a new scan, from the live mask, and the next channel of the running scan.
    always_comb begin
        first_s = find_ch(ch_mask, 3'd0);
        next_s  = find_ch(mask_q, {1'b0, sel_q} + 3'd1);
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        captured_d = captured_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // An empty mask skips the dwell entirely and publishes all zeros.
                    mask_d  = ch_mask;
                    busy_d  = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    sel_d   = first_s[1:0];
                    state_d = first_s[2] ? DWELL_S : DONE_S;
                end else begin
                    sel_d  = 2'b00;
                    busy_d = 1'b0;
                end
            end

            DWELL_S: begin
                if (cnt_q == CNT_LAST) begin
                    shadow_d[sel_q] = mux_out;
                    cnt_d           = {CW{1'b0}};
                    if (next_s[2]) begin
                        sel_d = next_s[1:0];
                    end else begin
                        // Stay on the last channel for the DONE_S cycle.
                        state_d = DONE_S;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE_S: begin
                // Publish the whole word at once, then clear the shadow for the next scan.
                done_d     = 1'b1;
                captured_d = shadow_q & mask_q;
                shadow_d   = 4'b0000;
                if (continuous) begin
                    mask_d  = ch_mask;
                    busy_d  = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    sel_d   = first_s[1:0];
                    state_d = first_s[2] ? DWELL_S : DONE_S;
                end else begin
                    state_d = IDLE;
                    sel_d   = 2'b00;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            captured_q <= 4'b0000;
            cnt_q      <= {CW{1'b0}};
            shadow_q   <= 4'b0000;
            mask_q     <= 4'b0000;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            captured_q <= captured_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
        end
    end

    assign sel      = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign captured = captured_q;

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Self-checking bench for mux41_scan_ctrl. The bench models the downstream
// 4x1 mux as mux_out = mux_i[sel] and derives the expected select sequence,
// done timing and capture word from the scan rules.
module tb_mux41_scan_ctrl;

    localparam int DW = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [3:0] ch_mask;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] captured;
    logic [3:0] mux_i;

    int total;
    int bad;

    mux41_scan_ctrl #(.DWELL(DW), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .mux_out    (mux_out),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .captured   (captured)
    );

    // Model of the downstream 4x1 mux.
    assign mux_out = mux_i[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] iv;
        logic [3:0] exp_cap;
        bit         noise;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-shot scan. k counts edges after the start edge E; values are read
    // 1 time unit after edge E+k.
    task automatic run_scan(input logic [3:0] m, input logic [3:0] iv,
                            input logic [3:0] exp_cap, input bit noise, input string nm);
        int chans[$];
        int n;
        int done_at;
        int done_cnt;
        logic [3:0] cap_seen;
        chans = {};
        for (int c = 0; c < 4; c++) begin
            if (m[c]) chans.push_back(c);
        end
        n          = chans.size();
        done_at    = -1;
        done_cnt   = 0;
        cap_seen   = 4'b0000;
        continuous = 1'b0;
        ch_mask    = m;
        mux_i      = iv;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= n * DW + 3; k++) begin
            if (k < n * DW) begin
                check({nm, " sel"}, 32'(sel), 32'(chans[k / DW]));
                check({nm, " busy"}, 32'(busy), 32'd1);
            end
            if (n == 0) check({nm, " sel0"}, 32'(sel), 32'd0);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at  = k;
                    cap_seen = captured;
                end
            end
            if (noise && k < n * DW) begin
                start   = 1'($urandom_range(0, 1));
                ch_mask = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check({nm, " done_at"}, 32'(done_at), 32'(n * DW + 1));
        check({nm, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({nm, " captured"}, 32'(cap_seen), 32'(exp_cap));
        check({nm, " idle busy"}, 32'(busy), 32'd0);
        check({nm, " idle sel"}, 32'(sel), 32'd0);
    endtask

    // Single channel 0 scan where mux input 0 rises after edge E+chg_k.
    task automatic sample_timing(input int chg_k, input logic [3:0] exp_cap, input string nm);
        logic [3:0] got;
        bit seen;
        seen    = 1'b0;
        got     = 4'hF;
        ch_mask = 4'b0001;
        mux_i   = 4'b0000;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done && !seen) begin
                seen = 1'b1;
                got  = captured;
            end
            if (k == chg_k) mux_i = 4'b0001;
            tick();
        end
        check({nm, " seen"}, 32'(seen), 32'd1);
        check({nm, " captured"}, 32'(got), 32'(exp_cap));
    endtask

    vec_t vecs[6];

    initial begin
        int dones[$];
        logic [3:0] caps[$];
        int busy_low;
        int rdone;
        logic [3:0] rm;
        logic [3:0] ri;

        total      = 0;
        bad        = 0;
        mux_i      = 4'b0000;
        ch_mask    = 4'b1111;
        continuous = 1'b0;

        // Reset held two cycles with start asserted.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check("rst sel", 32'(sel), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst captured", 32'(captured), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        tick();
        check("post rst idle busy", 32'(busy), 32'd0);

        vecs[0] = '{4'b1111, 4'b0101, 4'b0101, 1'b0};
        vecs[1] = '{4'b1010, 4'b1111, 4'b1010, 1'b0};
        vecs[2] = '{4'b0000, 4'b1111, 4'b0000, 1'b0};
        vecs[3] = '{4'b0110, 4'b1111, 4'b0110, 1'b1};
        vecs[4] = '{4'b1000, 4'b1000, 4'b1000, 1'b1};
        vecs[5] = '{4'b0001, 4'b1110, 4'b0000, 1'b0};
        for (int v = 0; v < 6; v++) begin
            run_scan(vecs[v].mask, vecs[v].iv, vecs[v].exp_cap, vecs[v].noise,
                     $sformatf("vec%0d", v));
        end

        sample_timing(2, 4'b0001, "sample early");
        sample_timing(4, 4'b0000, "sample late");

        // Continuous mode: input flips after the first done, continuous drops at E+20.
        ch_mask    = 4'b1111;
        mux_i      = 4'b1100;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        busy_low = 0;
        dones    = {};
        caps     = {};
        for (int k = 0; k < 42; k++) begin
            if (done) begin
                dones.push_back(k);
                caps.push_back(captured);
            end
            if (k < 34 && !busy) busy_low++;
            if (k == 17) mux_i = 4'b0011;
            if (k == 20) continuous = 1'b0;
            tick();
        end
        check("cont done count", 32'(dones.size()), 32'd2);
        if (dones.size() == 2) begin
            check("cont done1 at", 32'(dones[0]), 32'd17);
            check("cont done2 at", 32'(dones[1]), 32'd34);
            check("cont cap1", 32'(caps[0]), 32'b1100);
            check("cont cap2", 32'(caps[1]), 32'b0011);
        end
        check("cont busy held", 32'(busy_low), 32'd0);
        check("cont final busy", 32'(busy), 32'd0);
        check("cont final sel", 32'(sel), 32'd0);

        // Reset mid-scan, sampled at edge E+6.
        ch_mask = 4'b1111;
        mux_i   = 4'b1111;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        check("midrst sel", 32'(sel), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst captured", 32'(captured), 32'd0);
        rst   = 1'b0;
        rdone = 0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) rdone++;
            tick();
        end
        check("midrst no done", 32'(rdone), 32'd0);

        // Random scans against the model: capture = mask & input.
        for (int r = 0; r < 10; r++) begin
            rm = 4'($urandom_range(0, 15));
            ri = 4'($urandom_range(0, 15));
            run_scan(rm, ri, rm & ri, 1'b1, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
